flash_arbiter: RTL and testbench

Shares the single SPI flash byte reader (03h-read, one byte per transaction) between two burst requesters, e.g. PRG and CHR loaders. Accepts a start address plus byte count from each requester, grants one burst at a time, and drives the reader's valid/addr/ready/rdata handshake once per byte. Returns each byte to the granted requester with per-byte backpressure. Sits between the loaders and the flash byte reader.

---
 rtl/flash_arb_pkg.sv | 17 +
 rtl/flash_arb_grant.sv | 37 +++
 rtl/flash_arbiter.sv | 150 +++++++++++++++
 tb/tb_flash_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester SPI flash byte-read arbiter.
package flash_arb_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_DATA_W = 8;

    // Arbiter sequencing: wait for a burst, issue one byte read, hold the byte
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_e;

    // Index of the owning requester (0 or 1)
    typedef logic gnt_idx_t;

endpackage

// File: rtl/flash_arb_grant.sv
// Combinational winner select between the two burst requesters.
// Build option: define FLASH_ARB_RR_EN for round-robin tie breaking;
// without it requester 0 always wins a tie.
module flash_arb_grant
    import flash_arb_pkg::*;
(
    input  logic     req0_valid,
    input  logic     req1_valid,
    input  gnt_idx_t last_gnt,
    output logic     any_req,
    output gnt_idx_t winner
);

    assign any_req = req0_valid | req1_valid;

`ifdef FLASH_ARB_RR_EN
    // Tie goes to whichever requester did not own the previous burst
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_gnt;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end
`else
    // last_gnt is still tracked by the top but plays no part here
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    // Requester 0 has fixed priority
    always_comb begin
        winner = ~req0_valid;
    end
`endif

endmodule

// File: rtl/flash_arbiter.sv
// Shares one SPI flash byte reader between two burst requesters.
// Each accepted burst is issued to the reader one byte at a time; every byte
// is held for the owning requester until it is consumed before the next byte
// read is started, so the reader always sees valid drop between bytes.
// Build option: FLASH_ARB_RR_EN selects round-robin tie breaking (see
// flash_arb_grant); default is fixed priority to requester 0.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    req0_valid,
    input  logic [FLASH_ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]        req0_len,
    output logic                    req0_ready,

    input  logic                    req1_valid,
    input  logic [FLASH_ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]        req1_len,
    output logic                    req1_ready,

    output logic [FLASH_DATA_W-1:0] rd_data,
    output logic                    rd0_valid,
    input  logic                    rd0_ready,
    output logic                    rd1_valid,
    input  logic                    rd1_ready,
    output logic                    rd_last,

    output logic                    mem_valid,
    output logic [FLASH_ADDR_W-1:0] mem_addr,
    input  logic                    mem_ready,
    input  logic [FLASH_DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
    localparam logic [1:0] S_ISSUE = 2'(ARB_ISSUE);
    localparam logic [1:0] S_HOLD  = 2'(ARB_HOLD);

    logic [1:0]              state;
    gnt_idx_t                gnt;
    gnt_idx_t                last_gnt;
    logic [FLASH_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]        remain;
    logic [FLASH_DATA_W-1:0] data;

    logic     any_req;
    gnt_idx_t winner;
    logic     rd_ready_sel;
    logic     accept;
    logic     byte_done;
    logic     consume;
    logic     burst_end;

    flash_arb_grant u_grant (
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .last_gnt   (last_gnt),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign rd_ready_sel = gnt ? rd1_ready : rd0_ready;
    assign accept       = (state == S_IDLE)  && any_req;
    assign byte_done    = (state == S_ISSUE) && mem_ready;
    assign consume      = (state == S_HOLD)  && rd_ready_sel;
    assign burst_end    = (remain == '0);

    assign mem_addr = addr;
    assign rd_data  = data;

    // Sequencing and handshake outputs: accept pulse, byte request, byte hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            mem_valid  <= 1'b0;
            rd0_valid  <= 1'b0;
            rd1_valid  <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        gnt        <= winner;
                        req0_ready <= ~winner;
                        req1_ready <= winner;
                        mem_valid  <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (byte_done) begin
                        mem_valid <= 1'b0;
                        rd0_valid <= ~gnt;
                        rd1_valid <= gnt;
                        rd_last   <= burst_end;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        rd0_valid <= 1'b0;
                        rd1_valid <= 1'b0;
                        rd_last   <= 1'b0;
                        if (burst_end) begin
                            last_gnt <= gnt;
                            state    <= S_IDLE;
                        end else begin
                            mem_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Burst address/length capture and stepping, plus the returned byte
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr   <= '0;
            remain <= '0;
            data   <= '0;
        end else begin
            if (accept) begin
                addr   <= winner ? req1_addr : req0_addr;
                remain <= winner ? req1_len  : req0_len;
            end else if (consume && !burst_end) begin
                addr   <= addr + FLASH_ADDR_W'(1);
                remain <= remain - LEN_W'(1);
            end
            if (byte_done) begin
                data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a burst-level reference model.
module tb_flash_arbiter;

    localparam int LEN_W = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req0_valid, req1_valid;
    logic [23:0]       req0_addr, req1_addr;
    logic [LEN_W-1:0]  req0_len, req1_len;
    logic              req0_ready, req1_ready;
    logic [7:0]        rd_data;
    logic              rd0_valid, rd1_valid, rd0_ready, rd1_ready, rd_last;
    logic              mem_valid;
    logic [23:0]       mem_addr;
    logic              mem_ready;
    logic [7:0]        mem_rdata;

    int checks = 0;
    int errors = 0;

    flash_arbiter #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .rd_data    (rd_data),
        .rd0_valid  (rd0_valid),
        .rd0_ready  (rd0_ready),
        .rd1_valid  (rd1_valid),
        .rd1_ready  (rd1_ready),
        .rd_last    (rd_last),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- byte reader stub: data byte = address low byte ----------------
    int mem_delay = 0;
    int mem_cnt;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        mem_cnt   = 0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || mem_ready || !mem_valid) begin
                mem_ready = 1'b0;
                mem_cnt   = 0;
            end else if (mem_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr[7:0];
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
            end
        end
    end

    // ---------------- burst-level reference model and per-cycle compare ----------------
    bit          m_active;
    bit          m_owner;
    bit          m_last_gnt = 1'b1;
    logic [23:0] m_base;
    int          m_len, m_issue, m_rx;
    logic        p_req0v, p_req1v, p_mem_valid, p_mem_ready, p_rd_any, p_consumed;
    logic [23:0] p_a0, p_a1;
    logic [LEN_W-1:0] p_l0, p_l1;
    logic [7:0]  p_rd_data;
    logic [23:0] e_addr;
    logic [7:0]  e_byte;
    bit          n_acc, cons;
    int addr_log[$];
    int byte_log[$];
    int last_log[$];
    int gnt_log[$];

    function automatic bit model_winner(input bit r0, input bit r1, input bit lg);
`ifdef FLASH_ARB_RR_EN
        if (r0 && r1) return !lg;
`endif
        if (r0) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            m_active = 0; m_last_gnt = 1'b1; m_issue = 0; m_rx = 0;
            p_req0v = 0; p_req1v = 0; p_mem_valid = 0; p_mem_ready = 0;
            p_rd_any = 0; p_consumed = 0; p_rd_data = 0;
            p_a0 = 0; p_a1 = 0; p_l0 = 0; p_l1 = 0;
        end else begin
            chk("rd_excl", 32'(rd0_valid & rd1_valid), 0);
            chk("ready_excl", 32'(req0_ready & req1_ready), 0);
            if (p_mem_ready) chk("mem_gap", 32'(mem_valid), 0);
            if (req0_ready || req1_ready) begin
                n_acc = req1_ready;
                chk("accept_when_idle", 32'(m_active), 0);
                chk("grant_winner", 32'(n_acc), 32'(model_winner(p_req0v, p_req1v, m_last_gnt)));
                chk("accept_req_valid", 32'(n_acc ? p_req1v : p_req0v), 1);
                m_active = 1; m_owner = n_acc;
                m_base = n_acc ? p_a1 : p_a0;
                m_len  = n_acc ? int'(p_l1) : int'(p_l0);
                m_issue = 0; m_rx = 0;
                gnt_log.push_back(int'(n_acc));
            end
            if (mem_valid && !p_mem_valid) begin
                e_addr = m_base + 24'(m_issue);
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("issue_in_burst", 32'(m_active && m_issue <= m_len), 1);
                addr_log.push_back(int'(mem_addr));
                m_issue++;
            end
            if (p_rd_any && !p_consumed) begin
                chk("rd_held", 32'(rd0_valid | rd1_valid), 1);
                chk("rd_stable", 32'(rd_data), 32'(p_rd_data));
            end
            cons = 0;
            if (rd0_valid || rd1_valid) begin
                e_byte = 8'(m_base + 24'(m_rx));
                chk("rd_active", 32'(m_active), 1);
                chk("rd_owner", 32'(rd1_valid), 32'(m_owner));
                chk("rd_data", 32'(rd_data), 32'(e_byte));
                chk("rd_last", 32'(rd_last), 32'(m_rx == m_len));
                chk("hold_mem_idle", 32'(mem_valid), 0);
                if (!p_rd_any) chk("rd_after_mem_ready", 32'(p_mem_ready), 1);
                cons = rd1_valid ? rd1_ready : rd0_ready;
                if (cons) begin
                    byte_log.push_back(int'(rd_data));
                    last_log.push_back(int'(rd_last));
                    m_rx++;
                    if (m_rx > m_len) begin
                        m_active = 0;
                        m_last_gnt = m_owner;
                    end
                end
            end else begin
                chk("last_without_valid", 32'(rd_last), 0);
            end
            p_req0v = req0_valid; p_req1v = req1_valid;
            p_a0 = req0_addr; p_a1 = req1_addr; p_l0 = req0_len; p_l1 = req1_len;
            p_mem_valid = mem_valid; p_mem_ready = mem_ready;
            p_rd_any = rd0_valid | rd1_valid; p_consumed = cons; p_rd_data = rd_data;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_logs();
        addr_log.delete(); byte_log.delete(); last_log.delete(); gnt_log.delete();
    endtask

    task automatic chk_log(input string name, input int q[$], input int e[8], input int n);
        chk({name, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk(name, 32'(q[i]), 32'(e[i]));
        end
    endtask

    task automatic wait_ready(input bit n, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = n ? req1_ready : req0_ready;
        end
        @(posedge clk); #1;
        if (n) begin req1_valid = 0; req1_addr = 24'hABCDEF; req1_len = '1; end
        else   begin req0_valid = 0; req0_addr = 24'hABCDEF; req0_len = '1; end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL accept_timeout_req%0d: no ready in %0d cycles, required ready", n, budget);
        end
    endtask

    task automatic request(input bit n, input logic [23:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        if (n) begin req1_valid = 1; req1_addr = a; req1_len = l; end
        else   begin req0_valid = 1; req0_addr = a; req0_len = l; end
        wait_ready(n, 200);
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = !m_active && !req0_valid && !req1_valid && !rd0_valid && !rd1_valid && !mem_valid;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL burst_timeout: not idle after %0d cycles, required idle", budget);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
        chk({tag, "_rd0_valid"}, 32'(rd0_valid), 0);
        chk({tag, "_rd1_valid"}, 32'(rd1_valid), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rd_last"}, 32'(rd_last), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_len = 0; req1_len = 0;
        rd0_ready = 1; rd1_ready = 1;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Tie straight after reset: req0 first, then req1
        clear_logs();
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 24'h000100; req0_len = 8'd1;
        req1_valid = 1; req1_addr = 24'h000200; req1_len = 8'd0;
        wait_ready(1'b0, 50);
        wait_ready(1'b1, 50);
        wait_done(100);
        chk_log("tie_gnt", gnt_log, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
        chk_log("tie_bytes", byte_log, '{8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 0}, 3);

        // Single four-byte burst
        clear_logs();
        request(1'b0, 24'h010000, 8'd3);
        wait_done(100);
        chk_log("single_addr", addr_log, '{32'h010000, 32'h010001, 32'h010002, 32'h010003, 0, 0, 0, 0}, 4);
        chk_log("single_bytes", byte_log, '{8'h00, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0}, 4);
        chk_log("single_last", last_log, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        // Both requesters held for three accepts (previous owner was req0)
        clear_logs();
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 24'h000300; req0_len = 8'd0;
        req1_valid = 1; req1_addr = 24'h000400; req1_len = 8'd0;
        for (int i = 0; i < 200 && gnt_log.size() < 3; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_done(100);
`ifdef FLASH_ARB_RR_EN
        chk_log("hold_gnt", gnt_log, '{1, 0, 1, 0, 0, 0, 0, 0}, 3);
`else
        chk_log("hold_gnt", gnt_log, '{0, 0, 0, 0, 0, 0, 0, 0}, 3);
`endif

        // Backpressure on requester 1
        clear_logs();
        rd1_ready = 0;
        request(1'b1, 24'h000040, 8'd1);
        for (int i = 0; i < 50 && !rd1_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rd1_valid), 1);
            chk("bp_data", 32'(rd_data), 32'h40);
            chk("bp_mem_valid", 32'(mem_valid), 0);
        end
        @(posedge clk); #1;
        rd1_ready = 1;
        wait_done(100);
        chk_log("bp_bytes", byte_log, '{8'h40, 8'h41, 0, 0, 0, 0, 0, 0}, 2);

        // Address wrap inside a burst
        clear_logs();
        request(1'b0, 24'hFFFFFE, 8'd3);
        wait_done(100);
        chk_log("wrap_addr", addr_log, '{32'hFFFFFE, 32'hFFFFFF, 32'h000000, 32'h000001, 0, 0, 0, 0}, 4);
        chk_log("wrap_bytes", byte_log, '{8'hFE, 8'hFF, 8'h00, 8'h01, 0, 0, 0, 0}, 4);

        // Slow reader
        clear_logs();
        mem_delay = 2;
        request(1'b1, 24'h123456, 8'd2);
        wait_done(200);
        chk_log("slow_bytes", byte_log, '{8'h56, 8'h57, 8'h58, 0, 0, 0, 0, 0}, 3);

        // Reset while the second byte is being read
        mem_delay = 3;
        request(1'b0, 24'h000500, 8'd3);
        for (int i = 0; i < 100 && !(mem_valid && mem_addr == 24'h000501); i++) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset_hold");
        resetn = 1'b1;
        mem_delay = 0;
        clear_logs();
        request(1'b1, 24'h000700, 8'd1);
        wait_done(100);
        chk_log("after_reset_addr", addr_log, '{32'h000700, 32'h000701, 0, 0, 0, 0, 0, 0}, 2);
        chk_log("after_reset_bytes", byte_log, '{8'h00, 8'h01, 0, 0, 0, 0, 0, 0}, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
